usb_burst_reader: RTL and testbench

//  Read-side consumer of the 8192-word sample FIFO, running in the USB (outputClock) domain.

---
 rtl/dd_usb_pkg.sv | 24 ++
 rtl/usb_burst_counter.sv | 31 +++
 rtl/usb_burst_reader.sv | 94 +++++++++
 tb/tb_usb_burst_reader.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dd_usb_pkg.sv
// Shared definitions for the USB-side sample path: FSM state codes, FIFO geometry
// and default burst/word sizes.
package dd_usb_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FIFO_DEPTH = 8192;
    localparam int BURST_LEN  = 4096;
    localparam int CNT_WIDTH  = 13;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WAIT  = 3'd1;
    localparam logic [2:0] ARMED = 3'd2;
    localparam logic [2:0] BURST = 3'd3;
    localparam logic [2:0] ERROR = 3'd4;

    typedef enum logic [2:0] {
        stIdle  = IDLE,
        stWait  = WAIT,
        stArmed = ARMED,
        stBurst = BURST,
        stError = ERROR
    } readerState_t;

endpackage

// File: rtl/usb_burst_counter.sv
// Counts popped words within one burst and flags the last word of the burst.
module usb_burst_counter
    import dd_usb_pkg::*;
#(
    parameter int BURST_LEN = dd_usb_pkg::BURST_LEN,
    parameter int CNT_WIDTH = dd_usb_pkg::CNT_WIDTH
) (
    input  logic outputClock,
    input  logic nReset,
    input  logic clear,
    input  logic enable,
    output logic terminalCount
);

    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(BURST_LEN - 1);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge outputClock or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

    assign terminalCount = (count == LAST_COUNT);

endmodule

// File: rtl/usb_burst_reader.sv
// USB-domain reader of the sample FIFO: waits for half-full, then streams one
// fixed-length burst to the FX3, with sticky overflow detection.
//
//  state | meaning
//  IDLE  | capture disabled, nothing advertised
//  WAIT  | collecting, waiting for FIFO level above half
//  ARMED | burst advertised, waiting for FX3 to become ready
//  BURST | popping words to the FX3, paced by fx3Ready/empty
//  ERROR | FIFO overflowed; held until collectData drops
module usb_burst_reader
    import dd_usb_pkg::*;
#(
    parameter int DATA_WIDTH = dd_usb_pkg::DATA_WIDTH,
    parameter int BURST_LEN  = dd_usb_pkg::BURST_LEN,
    parameter int CNT_WIDTH  = dd_usb_pkg::CNT_WIDTH
) (
    input  logic                  outputClock,
    input  logic                  nReset,
    input  logic                  collectData,
    input  logic [DATA_WIDTH-1:0] fifoData,
    input  logic                  empty_flag,
    input  logic                  halfFull_flag,
    input  logic                  full_flag,
    input  logic                  fx3Ready,
    output logic                  outputAck,
    output logic [DATA_WIDTH-1:0] usbData,
    output logic                  usbValid,
    output logic                  dataAvailable,
    output logic                  overflowError
);

    readerState_t state, nextState;
    logic pop;
    logic clearCount;
    logic lastWord;

    usb_burst_counter #(
        .BURST_LEN(BURST_LEN),
        .CNT_WIDTH(CNT_WIDTH)
    ) burstCounter (
        .outputClock  (outputClock),
        .nReset       (nReset),
        .clear        (clearCount),
        .enable       (pop),
        .terminalCount(lastWord)
    );

    // Full blocks the pop in the same cycle so no word is read from a corrupted FIFO.
    assign pop = (state == stBurst) && fx3Ready && !empty_flag && collectData && !full_flag;
    assign outputAck = pop;

    always_comb begin
        nextState  = state;
        clearCount = 1'b0;
        if (!collectData) begin
            nextState = stIdle;
        end else if (full_flag && (state != stIdle)) begin
            nextState = stError;
        end else begin
            case (state)
                stIdle:  nextState = stWait;
                stWait: begin
                    if (halfFull_flag) begin
                        nextState  = stArmed;
                        clearCount = 1'b1;
                    end
                end
                stArmed: if (fx3Ready) nextState = stBurst;
                stBurst: if (pop && lastWord) nextState = stWait;
                stError: nextState = stError;
                default: nextState = stIdle;
            endcase
        end
    end

    always_ff @(posedge outputClock or negedge nReset) begin
        if (!nReset) begin
            state         <= stIdle;
            usbData       <= '0;
            usbValid      <= 1'b0;
            dataAvailable <= 1'b0;
            overflowError <= 1'b0;
        end else begin
            state         <= nextState;
            usbValid      <= pop;
            if (pop) begin
                usbData <= fifoData;
            end
            dataAvailable <= (nextState == stArmed) || (nextState == stBurst);
            overflowError <= (nextState == stError);
        end
    end

endmodule

// File: tb/tb_usb_burst_reader.sv
// Self-checking bench for usb_burst_reader: randomized FIFO contents and pacing,
// compared against a transaction-level model of the burst protocol.
module tb_usb_burst_reader;
    import dd_usb_pkg::*;

    localparam int BL    = BURST_LEN;
    localparam int DEPTH = FIFO_DEPTH;
    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_ARMED = 2, PH_BURST = 3, PH_ERROR = 4;

    logic        outputClock = 1'b0;
    logic        nReset = 1'b0;
    logic        collectData = 1'b0;
    logic [15:0] fifoData = 16'h0;
    logic        empty_flag = 1'b0;
    logic        halfFull_flag = 1'b0;
    logic        full_flag = 1'b0;
    logic        fx3Ready = 1'b0;
    logic        outputAck;
    logic [15:0] usbData;
    logic        usbValid;
    logic        dataAvailable;
    logic        overflowError;

    usb_burst_reader dut (
        .outputClock  (outputClock),
        .nReset       (nReset),
        .collectData  (collectData),
        .fifoData     (fifoData),
        .empty_flag   (empty_flag),
        .halfFull_flag(halfFull_flag),
        .full_flag    (full_flag),
        .fx3Ready     (fx3Ready),
        .outputAck    (outputAck),
        .usbData      (usbData),
        .usbValid     (usbValid),
        .dataAvailable(dataAvailable),
        .overflowError(overflowError)
    );

    always #5 outputClock = ~outputClock;

    int passCount = 0;
    int checkCount = 0;

    logic [15:0] fifoMem [DEPTH];
    int head = 0;

    // Reference model: protocol phase, expected next FIFO word and burst progress.
    int          mPhase;
    int          mIdx;
    int          mWords;
    logic [15:0] mData;
    logic        mValid, mAvail, mOvf;

    task automatic resetModel();
        mPhase = PH_IDLE;
        mWords = 0;
        mData  = 16'h0;
        mValid = 1'b0;
        mAvail = 1'b0;
        mOvf   = 1'b0;
    endtask

    function automatic logic expAck();
        return nReset && (mPhase == PH_BURST) && fx3Ready && !empty_flag && collectData && !full_flag;
    endfunction

    // One clock: FIFO follows the DUT's pops, the model follows the protocol rules.
    task automatic tick();
        logic mPop, dutPop;
        mPop   = expAck();
        dutPop = outputAck;
        @(posedge outputClock);
        #1;
        if (dutPop === 1'b1) head = (head + 1) % DEPTH;
        fifoData = fifoMem[head];
        if (!collectData) begin
            mPhase = PH_IDLE;
            mAvail = 1'b0;
            mOvf   = 1'b0;
            mValid = 1'b0;
        end else if (full_flag && mPhase != PH_IDLE) begin
            mPhase = PH_ERROR;
            mAvail = 1'b0;
            mOvf   = 1'b1;
            mValid = 1'b0;
        end else begin
            mValid = mPop;
            if (mPop) begin
                mData  = fifoMem[mIdx];
                mIdx   = (mIdx + 1) % DEPTH;
                mWords = mWords + 1;
            end
            case (mPhase)
                PH_IDLE:  mPhase = PH_WAIT;
                PH_WAIT:  if (halfFull_flag) begin mPhase = PH_ARMED; mAvail = 1'b1; mWords = 0; end
                PH_ARMED: if (fx3Ready) mPhase = PH_BURST;
                PH_BURST: if (mWords == BL) begin mPhase = PH_WAIT; mAvail = 1'b0; end
                default:  ;
            endcase
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        collectData = 1'b0; halfFull_flag = 1'b0; full_flag = 1'b0; empty_flag = 1'b0; fx3Ready = 1'b0;
        resetModel();
        mIdx = head;
        fifoData = fifoMem[head];
        repeat (3) @(posedge outputClock);
        #1;
        checkCount++;
        if ({usbValid, dataAvailable, overflowError, outputAck, usbData} !== 20'h0)
            $display("FAIL reset: got v=%b a=%b o=%b ack=%b d=%h, want all zero",
                     usbValid, dataAvailable, overflowError, outputAck, usbData);
        else passCount++;
        nReset = 1'b1;
    endtask

    task automatic test_idle_wait(input int cycles);
        collectData = 1'b1; halfFull_flag = 1'b0; fx3Ready = 1'b1; empty_flag = 1'b0; full_flag = 1'b0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            #1;
            checkCount++;
            if (outputAck !== 1'b0) $display("FAIL idle_ack cyc %0d: got %b want 0", cyc, outputAck);
            else passCount++;
            tick();
            checkCount++;
            if (dataAvailable !== 1'b0 || usbValid !== 1'b0)
                $display("FAIL idle_avail cyc %0d: got a=%b v=%b want 0 0", cyc, dataAvailable, usbValid);
            else passCount++;
        end
    endtask

    task automatic test_full_burst();
        int got, prevPhase;
        logic done;
        got = 0; done = 1'b0;
        collectData = 1'b1; halfFull_flag = 1'b1; fx3Ready = 1'b1; empty_flag = 1'b0; full_flag = 1'b0;
        for (int cyc = 0; cyc < BL + 50 && !done; cyc++) begin
            #1;
            checkCount++;
            if (outputAck !== expAck()) $display("FAIL full_ack cyc %0d: got %b want %b", cyc, outputAck, expAck());
            else passCount++;
            prevPhase = mPhase;
            tick();
            checkCount++;
            if ({usbValid, usbData, dataAvailable, overflowError} !== {mValid, mData, mAvail, mOvf})
                $display("FAIL full_out cyc %0d: got v=%b d=%h a=%b o=%b want v=%b d=%h a=%b o=%b",
                         cyc, usbValid, usbData, dataAvailable, overflowError, mValid, mData, mAvail, mOvf);
            else passCount++;
            if (usbValid === 1'b1) got++;
            if (prevPhase == PH_BURST && mPhase == PH_WAIT) done = 1'b1;
        end
        checkCount++;
        if (!done || got != BL) $display("FAIL full_words: got %0d words done=%b want %0d", got, done, BL);
        else passCount++;
        checkCount++;
        if (dataAvailable !== 1'b0) $display("FAIL full_gap: got dataAvailable=%b want 0", dataAvailable);
        else passCount++;
    endtask

    task automatic test_stall();
        int got, prevPhase, stallLeft;
        logic done, stalled;
        got = 0; done = 1'b0; stalled = 1'b0; stallLeft = 0;
        collectData = 1'b1; halfFull_flag = 1'b1; empty_flag = 1'b0; full_flag = 1'b0;
        for (int cyc = 0; cyc < BL + 80 && !done; cyc++) begin
            if (!stalled && mPhase == PH_BURST && mWords == 1000) begin
                stalled = 1'b1;
                stallLeft = 10;
            end
            fx3Ready = (stallLeft == 0);
            #1;
            checkCount++;
            if (outputAck !== expAck()) $display("FAIL stall_ack cyc %0d: got %b want %b", cyc, outputAck, expAck());
            else passCount++;
            prevPhase = mPhase;
            tick();
            if (stallLeft > 0) stallLeft--;
            checkCount++;
            if ({usbValid, usbData, dataAvailable, overflowError} !== {mValid, mData, mAvail, mOvf})
                $display("FAIL stall_out cyc %0d: got v=%b d=%h a=%b o=%b want v=%b d=%h a=%b o=%b",
                         cyc, usbValid, usbData, dataAvailable, overflowError, mValid, mData, mAvail, mOvf);
            else passCount++;
            if (usbValid === 1'b1) got++;
            if (prevPhase == PH_BURST && mPhase == PH_WAIT) done = 1'b1;
        end
        checkCount++;
        if (!done || !stalled || got != BL)
            $display("FAIL stall_words: got %0d words done=%b stalled=%b want %0d", got, done, stalled, BL);
        else passCount++;
    endtask

    task automatic test_random_pacing();
        int got, prevPhase;
        logic done;
        got = 0; done = 1'b0;
        collectData = 1'b1; halfFull_flag = 1'b1; full_flag = 1'b0;
        for (int cyc = 0; cyc < BL * 4 && !done; cyc++) begin
            fx3Ready   = ($urandom_range(0, 3) != 0);
            empty_flag = ($urandom_range(0, 7) == 0);
            #1;
            checkCount++;
            if (outputAck !== expAck()) $display("FAIL rand_ack cyc %0d: got %b want %b", cyc, outputAck, expAck());
            else passCount++;
            prevPhase = mPhase;
            tick();
            checkCount++;
            if ({usbValid, usbData, dataAvailable, overflowError} !== {mValid, mData, mAvail, mOvf})
                $display("FAIL rand_out cyc %0d: got v=%b d=%h a=%b o=%b want v=%b d=%h a=%b o=%b",
                         cyc, usbValid, usbData, dataAvailable, overflowError, mValid, mData, mAvail, mOvf);
            else passCount++;
            if (usbValid === 1'b1) got++;
            if (prevPhase == PH_BURST && mPhase == PH_WAIT) done = 1'b1;
        end
        empty_flag = 1'b0;
        checkCount++;
        if (!done || got != BL) $display("FAIL rand_words: got %0d words done=%b want %0d", got, done, BL);
        else passCount++;
    endtask

    task automatic test_overflow();
        int cyc;
        cyc = 0;
        collectData = 1'b1; halfFull_flag = 1'b1; fx3Ready = 1'b1; empty_flag = 1'b0; full_flag = 1'b0;
        while (!(mPhase == PH_BURST && mWords == 100) && cyc < 300) begin
            #1;
            tick();
            checkCount++;
            if ({usbValid, usbData, dataAvailable} !== {mValid, mData, mAvail})
                $display("FAIL ovf_pre cyc %0d: got v=%b d=%h a=%b want v=%b d=%h a=%b",
                         cyc, usbValid, usbData, dataAvailable, mValid, mData, mAvail);
            else passCount++;
            cyc++;
        end
        checkCount++;
        if (cyc >= 300) $display("FAIL ovf_reach: burst word 100 not reached in %0d cycles", cyc);
        else passCount++;
        full_flag = 1'b1;
        #1;
        checkCount++;
        if (outputAck !== 1'b0) $display("FAIL ovf_ack: got %b want 0 while full", outputAck);
        else passCount++;
        tick();
        full_flag = 1'b0;
        checkCount++;
        if ({overflowError, dataAvailable, usbValid} !== 3'b100)
            $display("FAIL ovf_set: got o=%b a=%b v=%b want 1 0 0", overflowError, dataAvailable, usbValid);
        else passCount++;
        for (int i = 0; i < 6; i++) begin
            #1;
            checkCount++;
            if (outputAck !== 1'b0 || overflowError !== 1'b1)
                $display("FAIL ovf_hold %0d: got ack=%b o=%b want 0 1", i, outputAck, overflowError);
            else passCount++;
            tick();
        end
        collectData = 1'b0;
        #1;
        tick();
        checkCount++;
        if ({overflowError, dataAvailable} !== {mOvf, mAvail} || overflowError !== 1'b0)
            $display("FAIL ovf_clear: got o=%b a=%b want 0 0", overflowError, dataAvailable);
        else passCount++;
    endtask

    task automatic test_abandon();
        int cyc, got, prevPhase;
        logic done;
        cyc = 0; got = 0; done = 1'b0;
        collectData = 1'b1; halfFull_flag = 1'b1; fx3Ready = 1'b1; empty_flag = 1'b0; full_flag = 1'b0;
        while (!(mPhase == PH_BURST && mWords == 2000) && cyc < 2100) begin
            #1;
            tick();
            checkCount++;
            if ({usbValid, usbData, dataAvailable} !== {mValid, mData, mAvail})
                $display("FAIL abandon_pre cyc %0d: got v=%b d=%h a=%b want v=%b d=%h a=%b",
                         cyc, usbValid, usbData, dataAvailable, mValid, mData, mAvail);
            else passCount++;
            cyc++;
        end
        collectData = 1'b0;
        #1;
        checkCount++;
        if (outputAck !== 1'b0 || cyc >= 2100)
            $display("FAIL abandon_ack: got %b want 0 (cycles %0d)", outputAck, cyc);
        else passCount++;
        tick();
        checkCount++;
        if (dataAvailable !== 1'b0 || usbValid !== 1'b0)
            $display("FAIL abandon_idle: got a=%b v=%b want 0 0", dataAvailable, usbValid);
        else passCount++;
        collectData = 1'b1;
        for (int c = 0; c < BL + 50 && !done; c++) begin
            #1;
            checkCount++;
            if (outputAck !== expAck()) $display("FAIL restart_ack cyc %0d: got %b want %b", c, outputAck, expAck());
            else passCount++;
            prevPhase = mPhase;
            tick();
            checkCount++;
            if ({usbValid, usbData, dataAvailable, overflowError} !== {mValid, mData, mAvail, mOvf})
                $display("FAIL restart_out cyc %0d: got v=%b d=%h a=%b o=%b want v=%b d=%h a=%b o=%b",
                         c, usbValid, usbData, dataAvailable, overflowError, mValid, mData, mAvail, mOvf);
            else passCount++;
            if (usbValid === 1'b1) got++;
            if (prevPhase == PH_BURST && mPhase == PH_WAIT) done = 1'b1;
        end
        checkCount++;
        if (!done || got != BL) $display("FAIL restart_words: got %0d words done=%b want %0d", got, done, BL);
        else passCount++;
    endtask

    task automatic test_async_reset();
        int cyc;
        cyc = 0;
        collectData = 1'b1; halfFull_flag = 1'b1; fx3Ready = 1'b1; empty_flag = 1'b0; full_flag = 1'b0;
        while (!(mPhase == PH_BURST && mWords == 3000) && cyc < 3100) begin
            #1;
            tick();
            cyc++;
        end
        checkCount++;
        if (cyc >= 3100 || usbValid !== 1'b1 || dataAvailable !== 1'b1)
            $display("FAIL areset_reach: cycles %0d v=%b a=%b want burst in progress", cyc, usbValid, dataAvailable);
        else passCount++;
        nReset = 1'b0;
        #1;
        checkCount++;
        if ({usbValid, dataAvailable, overflowError, outputAck, usbData} !== 20'h0)
            $display("FAIL areset_async: got v=%b a=%b o=%b ack=%b d=%h want all zero",
                     usbValid, dataAvailable, overflowError, outputAck, usbData);
        else passCount++;
        resetModel();
        repeat (2) @(posedge outputClock);
        #1;
        nReset = 1'b1;
        test_idle_wait(20);
    endtask

    initial begin
        foreach (fifoMem[i]) fifoMem[i] = 16'($urandom);
        test_reset();
        test_idle_wait(40);
        test_full_burst();
        test_stall();
        test_random_pacing();
        test_overflow();
        test_abandon();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
